// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Defining CLA_OVERFLOW_DETECT_EN adds a registered signed-overflow output (ovf).
module pipelined_cla_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             p_out,
   output logic             g_out
`ifdef CLA_OVERFLOW_DETECT_EN
   ,
   output logic             ovf
`endif
);
   localparam int unsigned NG = WIDTH / 4;
   localparam int unsigned NS = (NG + 3) / 4;

   // Carry out of the lowest n units from unit P/G and carry-in, in flat sum-of-products form.
   function automatic logic lookahead(input logic [15:0] p, input logic [15:0] g,
                                      input int unsigned n, input logic c);
      logic acc;
      logic prod;
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = 15; j >= 0; j--) begin
         if (j < int'(n)) begin
            acc  = acc | (prod & g[j]);
            prod = prod & p[j];
         end
      end
      return acc | (prod & c);
   endfunction

   // Handshake
   logic s1_valid_q, s1_valid_d;
   logic out_valid_q, out_valid_d;
   logic s2_adv, s1_adv, accept, load2;

   always_comb begin
      s2_adv   = !out_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      accept   = in_valid && s1_adv;
      load2    = s2_adv && s1_valid_q;
      in_ready = s1_adv;
   end

   // Stage 1: bit and group propagate/generate
   logic [WIDTH-1:0]      b_eff, bit_p, bit_g;
   logic [NG-1:0]         grp_p, grp_g;
   logic [WIDTH-1:0]      p_q, p_d;
   // Bit 3 of each group's G only feeds the group generate, so it is not kept.
   logic [NG-1:0][2:0]    g_q, g_d;
   logic [NG-1:0]         grp_p_q, grp_p_d, grp_g_q, grp_g_d;
   logic                  c0_q, c0_d;

   always_comb begin
      b_eff = sub ? ~b : b;
      bit_p = a ^ b_eff;
      bit_g = a & b_eff;
      for (int k = 0; k < int'(NG); k++) begin
         grp_p[k] = &bit_p[4*k +: 4];
         grp_g[k] = bit_g[4*k+3]
                  | (bit_p[4*k+3] & bit_g[4*k+2])
                  | (&bit_p[4*k+3 -: 2] & bit_g[4*k+1])
                  | (&bit_p[4*k+3 -: 3] & bit_g[4*k]);
      end
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      p_d        = p_q;
      g_d        = g_q;
      grp_p_d    = grp_p_q;
      grp_g_d    = grp_g_q;
      c0_d       = c0_q;
      if (accept) begin
         p_d     = bit_p;
         for (int k = 0; k < int'(NG); k++) g_d[k] = bit_g[4*k +: 3];
         grp_p_d = grp_p;
         grp_g_d = grp_g;
         c0_d    = sub | cin;
      end
   end

   // Stage 2: group carries, bit carries and sum
   logic [NG:0]      gc;
   logic             word_g;
   logic [WIDTH-1:0] ci;

   if (NG <= 4) begin : g_single
      always_comb begin
         gc[0] = c0_q;
         for (int k = 0; k < int'(NG); k++) begin
            gc[k+1] = lookahead(16'(grp_p_q), 16'(grp_g_q), k + 1, c0_q);
         end
         word_g = lookahead(16'(grp_p_q), 16'(grp_g_q), NG, 1'b0);
      end
   end else begin : g_two
      logic [4*NS-1:0] gpx, ggx;
      logic [NS-1:0]   sp, sg, sc;
      always_comb begin
         // Missing groups in the top super-group are padded as transparent.
         gpx          = '1;
         ggx          = '0;
         gpx[NG-1:0]  = grp_p_q;
         ggx[NG-1:0]  = grp_g_q;
         for (int s = 0; s < int'(NS); s++) begin
            sp[s] = &gpx[4*s +: 4];
            sg[s] = lookahead(16'(gpx[4*s +: 4]), 16'(ggx[4*s +: 4]), 4, 1'b0);
         end
         for (int s = 0; s < int'(NS); s++) begin
            sc[s] = lookahead(16'(sp), 16'(sg), s, c0_q);
         end
         gc[0] = c0_q;
         for (int k = 0; k < int'(NG); k++) begin
            gc[k+1] = lookahead(16'(gpx[4*(k/4) +: 4]), 16'(ggx[4*(k/4) +: 4]),
                                (k % 4) + 1, sc[k/4]);
         end
         word_g = lookahead(16'(sp), 16'(sg), NS, 1'b0);
      end
   end

   always_comb begin
      for (int k = 0; k < int'(NG); k++) begin
         for (int i = 0; i < 4; i++) begin
            ci[4*k+i] = lookahead(16'(p_q[4*k +: 4]), 16'(g_q[k]), i, gc[k]);
         end
      end
   end

   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d, p_out_q, p_out_d, g_out_q, g_out_d;
`ifdef CLA_OVERFLOW_DETECT_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      p_out_d     = p_out_q;
      g_out_d     = g_out_q;
`ifdef CLA_OVERFLOW_DETECT_EN
      ovf_d       = ovf_q;
`endif
      if (load2) begin
         sum_d   = p_q ^ ci;
         cout_d  = gc[NG];
         p_out_d = &grp_p_q;
         g_out_d = word_g;
`ifdef CLA_OVERFLOW_DETECT_EN
         ovf_d   = ci[WIDTH-1] ^ gc[NG];
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         p_q         <= '0;
         g_q         <= '0;
         grp_p_q     <= '0;
         grp_g_q     <= '0;
         c0_q        <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         p_out_q     <= 1'b0;
         g_out_q     <= 1'b0;
`ifdef CLA_OVERFLOW_DETECT_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         p_q         <= p_d;
         g_q         <= g_d;
         grp_p_q     <= grp_p_d;
         grp_g_q     <= grp_g_d;
         c0_q        <= c0_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         p_out_q     <= p_out_d;
         g_out_q     <= g_out_d;
`ifdef CLA_OVERFLOW_DETECT_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   always_comb begin
      out_valid = out_valid_q;
      sum       = sum_q;
      cout      = cout_q;
      p_out     = p_out_q;
      g_out     = g_out_q;
`ifdef CLA_OVERFLOW_DETECT_EN
      ovf       = ovf_q;
`endif
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: WIDTH 4, 16 and 32 instances share stimulus,
// each with its own scoreboard queue; vector table for WIDTH=16 plus stall/reset sequences.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        p;
      logic        g;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        p;
      logic        g;
      logic        ovf;
   } vec_t;

   logic        clk, rst, in_valid, cin, sub, out_ready, rand_bp;
   logic [31:0] in_a, in_b;
   logic        in_ready4, in_ready16, in_ready32;
   logic        out_valid4, out_valid16, out_valid32;
   logic [3:0]  sum4;
   logic [15:0] sum16;
   logic [31:0] sum32;
   logic        cout4, cout16, cout32, p4, p16, p32, g4, g16, g32;
`ifdef CLA_OVERFLOW_DETECT_EN
   logic        ovf4, ovf16, ovf32;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t cur16;
   exp_t em;
   exp_t q4[$];
   exp_t q16[$];
   exp_t q32[$];
   vec_t tbl[11];

   pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .a(in_a[3:0]), .b(in_b[3:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .cout(cout4),
      .p_out(p4), .g_out(g4)
`ifdef CLA_OVERFLOW_DETECT_EN
      , .ovf(ovf4)
`endif
   );

   pipelined_cla_adder #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
      .a(in_a[15:0]), .b(in_b[15:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16), .cout(cout16),
      .p_out(p16), .g_out(g16)
`ifdef CLA_OVERFLOW_DETECT_EN
      , .ovf(ovf16)
`endif
   );

   pipelined_cla_adder #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .a(in_a), .b(in_b), .cin(cin), .sub(sub),
      .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32), .cout(cout32),
      .p_out(p32), .g_out(g32)
`ifdef CLA_OVERFLOW_DETECT_EN
      , .ovf(ovf32)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic cv, input logic sv);
      exp_t        e;
      logic [31:0] mask, am, bm;
      logic [32:0] full, nocin;
      mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      am     = av & mask;
      bm     = (sv ? ~bv : bv) & mask;
      full   = {1'b0, am} + {1'b0, bm} + {32'b0, sv | cv};
      nocin  = {1'b0, am} + {1'b0, bm};
      e.sum  = full[31:0] & mask;
      e.cout = full[w];
      e.p    = &((am ^ bm) | ~mask);
      e.g    = nocin[w];
      e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic [31:0] s, input logic c,
                      input logic p, input logic g);
      check({tag, "_sum"}, 64'(s), 64'(e.sum));
      check({tag, "_cout"}, 64'(c), 64'(e.cout));
      check({tag, "_p_out"}, 64'(p), 64'(e.p));
      check({tag, "_g_out"}, 64'(g), 64'(e.g));
   endtask

   task automatic underflow(input string tag);
      n_tests++;
      n_fail++;
      $display("FAIL %s_underflow: got out_valid=1, want no pending beat", tag);
   endtask

   // Scoreboard: push on accept, pop on output transfer, both sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_ready && out_valid16) begin
            if (q16.size() == 0) underflow("o16");
            else begin
               em = q16.pop_front();
               cmp("o16", em, 32'(sum16), cout16, p16, g16);
`ifdef CLA_OVERFLOW_DETECT_EN
               check("o16_ovf", 64'(ovf16), 64'(em.ovf));
`endif
            end
         end
         if (out_ready && out_valid4) begin
            if (q4.size() == 0) underflow("o4");
            else begin
               em = q4.pop_front();
               cmp("o4", em, 32'(sum4), cout4, p4, g4);
`ifdef CLA_OVERFLOW_DETECT_EN
               check("o4_ovf", 64'(ovf4), 64'(em.ovf));
`endif
            end
         end
         if (out_ready && out_valid32) begin
            if (q32.size() == 0) underflow("o32");
            else begin
               em = q32.pop_front();
               cmp("o32", em, sum32, cout32, p32, g32);
`ifdef CLA_OVERFLOW_DETECT_EN
               check("o32_ovf", 64'(ovf32), 64'(em.ovf));
`endif
            end
         end
         if (in_valid && in_ready16) q16.push_back(cur16);
         if (in_valid && in_ready4)  q4.push_back(model(4, in_a, in_b, cin, sub));
         if (in_valid && in_ready32) q32.push_back(model(32, in_a, in_b, cin, sub));
      end
   end

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic sv, input exp_t e16);
      logic acc;
      in_a     = av;
      in_b     = bv;
      cin      = cv;
      sub      = sv;
      cur16    = e16;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (rand_bp) out_ready = ($urandom_range(3) != 0);
         @(negedge clk);
         acc = in_ready16;
         @(posedge clk);
         #1;
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want accept");
   endtask

   task automatic wait_idle();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (q16.size() == 0 && q4.size() == 0 && q32.size() == 0 && !out_valid16) return;
         @(posedge clk);
         #1;
      end
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, want 0", q16.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      rand_bp   = 1'b0;
      cur16     = model(16, 0, 0, 0, 0);

      //          a             b             cin   sub   sum       cout  p     g     ovf
      tbl[0]  = '{32'h1234,     32'h4321,     1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{32'hFFFFFFFF, 32'h0001,     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{32'h0005,     32'h0007,     1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{32'h0007,     32'h0005,     1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{32'h7FFF,     32'h0001,     1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{32'h00FF,     32'h0F00,     1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{32'hAAAA,     32'h5555,     1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{32'h8000,     32'h8000,     1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{32'h8000,     32'h8000,     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{32'h0005,     32'h0007,     1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{32'h0007,     32'h0005,     1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0};

      #1;
      check("rst_out_valid", 64'(out_valid16), 64'd0);
      check("rst_sum", 64'(sum16), 64'd0);
      check("rst_cout", 64'(cout16), 64'd0);
      check("rst_p_out", 64'(p16), 64'd0);
      check("rst_g_out", 64'(g16), 64'd0);
      check("rst_out_valid32", 64'(out_valid32), 64'd0);
      #11 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready16), 64'd1);

      // Latency: accepted at edge N, result registered at edge N+1, seen by consumer at N+2.
      @(posedge clk);
      #1;
      in_a     = 32'h1234;
      in_b     = 32'h4321;
      cur16    = model(16, 32'h1234, 32'h4321, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("lat_edge_n_valid", 64'(out_valid16), 64'd0);
      @(posedge clk);
      #1;
      check("lat_edge_n1_valid", 64'(out_valid16), 64'd1);
      check("lat_edge_n1_sum", 64'(sum16), 64'h5555);
      check("lat_edge_n1_cout", 64'(cout16), 64'd0);
      wait_idle();

      for (int i = 0; i < 11; i++) begin
         e.sum  = 32'(tbl[i].sum);
         e.cout = tbl[i].cout;
         e.p    = tbl[i].p;
         e.g    = tbl[i].g;
         e.ovf  = tbl[i].ovf;
         send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
      end
      wait_idle();

      // Stall: two beats fill the pipe, third is held off until out_ready returns.
      out_ready = 1'b0;
      send(32'd1, 32'd1, 1'b0, 1'b0, model(16, 1, 1, 0, 0));
      send(32'd2, 32'd2, 1'b0, 1'b0, model(16, 2, 2, 0, 0));
      in_a     = 32'd3;
      in_b     = 32'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready16), 64'd0);
         check("stall_out_valid", 64'(out_valid16), 64'd1);
         check("stall_sum", 64'(sum16), 64'h0002);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'd3, 32'd3, 1'b0, 1'b0, model(16, 3, 3, 0, 0));
      wait_idle();

      // Asynchronous reset with two beats in flight.
      out_ready = 1'b0;
      send(32'd9, 32'd9, 1'b0, 1'b0, model(16, 9, 9, 0, 0));
      send(32'd10, 32'd10, 1'b0, 1'b0, model(16, 10, 10, 0, 0));
      #1 rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid16), 64'd0);
      check("arst_sum", 64'(sum16), 64'd0);
      check("arst_out_valid32", 64'(out_valid32), 64'd0);
      q4.delete();
      q16.delete();
      q32.delete();
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("arst_in_ready", 64'(in_ready16), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("arst_no_stale", 64'(out_valid16), 64'd0);
         check("arst_no_stale32", 64'(out_valid32), 64'd0);
      end

      // Random operands with random backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra, rb;
         logic        rc, rs;
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(1));
         rs = 1'($urandom_range(1));
         send(ra, rb, rc, rs, model(16, ra, rb, rc, rs));
      end
      rand_bp = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
